// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, memory geometry and fetch FSM state encoding.
package fetch_ctrl_pkg;
  localparam int ADDR_W     = 24;
  localparam int INST_W     = 24;
  localparam int INST_BYTES = 3;
  localparam int MEM_BYTES  = 64;
  localparam int RESET_PC   = 0;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;
endpackage

// File: rtl/fetch_ctrl_fifo.sv
// fetch_ctrl_fifo: 2-entry in-order {pc,inst} buffer; the head is a plain register so out_* carry no comb path.
module fetch_ctrl_fifo #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_count
);
  logic [W-1:0] r_head, r_tail;
  logic [1:0]   r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      if (i_pop) r_head <= (r_count == 2'd2) ? r_tail : i_data;
      else if (i_push && r_count == 2'd0) r_head <= i_data;
      if (i_push && (r_count == 2'd2 || (r_count == 2'd1 && !i_pop))) r_tail <= i_data;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  assign o_head  = r_head;
  assign o_count = r_count;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer; owns the PC, issues 1-cycle-latency memory reads,
// buffers results for decode, handles redirects and faults on out-of-range fetch.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] im_pc,
  input  logic [INST_W-1:0] im_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - INST_BYTES);
  state_t                   r_state;
  logic [ADDR_W-1:0]        r_pc, r_req, r_fault_pc;
  logic                     r_inflight, r_fault;
  logic [1:0]               w_count;
  logic [ADDR_W+INST_W-1:0] w_head;
  logic                     w_pop, w_room, w_try, w_legal, w_issue, w_push;
  assign w_pop   = out_valid & out_ready;
  assign w_legal = r_pc <= LAST_PC;
  // The slot freed by a same-cycle pop counts, so a held-ready stream sustains one per cycle.
  assign w_room  = (3'(w_count) + 3'(r_inflight)) < (3'd2 + 3'(w_pop));
  assign w_try   = (r_state == ST_RUN) & w_room & !redirect_valid;
  assign w_issue = w_try & w_legal;
  assign w_push  = r_inflight & !redirect_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= ADDR_W'(RESET_PC);
      r_req      <= '0;
      r_inflight <= 1'b0;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      if (r_state == ST_FAULT && redirect_pc > LAST_PC) begin
        r_fault_pc <= redirect_pc;
      end else begin
        r_state <= en ? ST_RUN : ST_IDLE;
        r_fault <= 1'b0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req <= r_pc;
        r_pc  <= r_pc + ADDR_W'(INST_BYTES);
      end
      if (w_try && !w_legal) begin
        r_state    <= ST_FAULT;
        r_fault    <= 1'b1;
        r_fault_pc <= r_pc;
      end else if (r_state != ST_FAULT) begin
        r_state <= en ? ST_RUN : ST_IDLE;
      end
    end
  end
  fetch_ctrl_fifo #(.W(ADDR_W + INST_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_data  ({r_req, im_inst}),
    .o_head  (w_head),
    .o_count (w_count)
  );
  assign im_pc     = r_pc;
  assign out_valid = w_count != 2'd0;
  assign out_pc    = w_head[ADDR_W+INST_W-1:INST_W];
  assign out_inst  = w_head[INST_W-1:0];
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenarios plus random stimulus against a queue-based reference model.
module tb_fetch_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [23:0] im_pc, im_inst = '0, redirect_pc = '0, out_inst, out_pc, fault_pc;
  logic        out_valid, fault;
  int          n_chk = 0, n_fail = 0;
  int          m_mode;
  bit          m_busy;
  logic [23:0] m_pc, m_req, m_fpc;
  logic [47:0] m_q[$];
  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .im_pc(im_pc), .im_inst(im_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc)
  );
  always #5 clk = ~clk;
  function automatic logic [23:0] mem(input logic [23:0] p);
    logic [7:0] b;
    b = p[7:0];
    return {b, b + 8'd1, b + 8'd2};
  endfunction
  always @(posedge clk) im_inst <= mem(im_pc);
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference model: mode 0 idle, 1 running, 2 faulted; queue holds delivered-order {pc,inst}.
  task automatic model_step();
    bit pop, room, legal;
    pop   = m_q.size() != 0 && out_ready;
    room  = (m_q.size() + int'(m_busy) - int'(pop)) < 2;
    legal = m_pc <= 24'd61;
    if (pop) void'(m_q.pop_front());
    if (redirect_valid) begin
      m_q.delete();
      m_busy = 0;
      if (m_mode == 2 && redirect_pc > 24'd61) m_fpc = redirect_pc;
      else m_mode = en ? 1 : 0;
      m_pc = redirect_pc;
    end else begin
      if (m_busy) m_q.push_back({m_req, mem(m_req)});
      m_busy = 0;
      if (m_mode == 1 && room && legal) begin
        m_busy = 1;
        m_req  = m_pc;
        m_pc   = m_pc + 24'd3;
      end
      if (m_mode == 1 && room && !legal) begin
        m_mode = 2;
        m_fpc  = m_pc;
      end else if (m_mode != 2) m_mode = en ? 1 : 0;
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = '0; m_req = '0; m_fpc = '0; m_busy = 0;
      m_q.delete();
    end else model_step();
  end
  task automatic compare();
    chk("out_valid", 48'(out_valid), 48'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      chk("out_pc", 48'(out_pc), 48'(m_q[0][47:24]));
      chk("out_inst", 48'(out_inst), 48'(m_q[0][23:0]));
    end
    chk("fault", 48'(fault), 48'(m_mode == 2));
    chk("fault_pc", 48'(fault_pc), 48'(m_fpc));
    chk("im_pc", 48'(im_pc), 48'(m_pc));
  endtask
  task automatic step(input bit e, input bit r, input bit rv, input logic [23:0] rp);
    en = e; out_ready = r; redirect_valid = rv; redirect_pc = rp;
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    en = 0; out_ready = 0; redirect_valid = 0;
    rst_n = 0;
    #1;
    chk("rst_valid", 48'(out_valid), 48'd0);
    chk("rst_pc", 48'(out_pc), 48'd0);
    chk("rst_inst", 48'(out_inst), 48'd0);
    chk("rst_fault", 48'(fault), 48'd0);
    chk("rst_fault_pc", 48'(fault_pc), 48'd0);
    chk("rst_im_pc", 48'(im_pc), 48'd0);
    @(negedge clk);
    rst_n = 1;
  endtask
  initial begin
    logic [23:0] first_inst[3];
    logic [23:0] exp_pc, last_pc;
    int          seen;
    first_inst[0] = 24'h000102; first_inst[1] = 24'h030405; first_inst[2] = 24'h060708;
    @(negedge clk);
    do_reset();
    // 1: latency and back-to-back delivery
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      if (i < 2) chk("t1_latency", 48'(out_valid), 48'd0);
      else begin
        chk("t1_valid", 48'(out_valid), 48'd1);
        chk("t1_pc", 48'(out_pc), 48'(3 * (i - 2)));
        if (i < 5) chk("t1_inst", 48'(out_inst), 48'(first_inst[i - 2]));
      end
    end
    // 2: backpressure holds the head; release continues strictly +3
    exp_pc = out_pc;
    repeat (6) step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", 48'(out_valid), 48'd1);
      chk("t2_pc", 48'(out_pc), 48'(exp_pc));
      exp_pc = exp_pc + 24'd3;
      step(1, 1, 0, 0);
    end
    // 3: redirect with buffer holding 9,12
    do_reset();
    for (int i = 0; i < 20 && !(out_valid && out_pc == 24'd9); i++) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    step(1, 0, 1, 24'h1E);
    for (int i = 0; i < 10 && !out_valid; i++) step(1, 0, 0, 0);
    chk("t3_valid", 48'(out_valid), 48'd1);
    chk("t3_pc", 48'(out_pc), 48'h1E);
    chk("t3_inst", 48'(out_inst), 48'h1E1F20);
    // 4: run off the end of memory, then recover
    do_reset();
    last_pc = '1;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0);
      if (out_valid) last_pc = out_pc;
    end
    chk("t4_last_pc", 48'(last_pc), 48'd60);
    chk("t4_fault", 48'(fault), 48'd1);
    chk("t4_fault_pc", 48'(fault_pc), 48'd63);
    step(1, 1, 1, 0);
    for (int i = 0; i < 10 && !out_valid; i++) step(1, 1, 0, 0);
    chk("t4_recover_fault", 48'(fault), 48'd0);
    chk("t4_recover_pc", 48'(out_pc), 48'd0);
    // 5: en drops with one fetch in flight
    do_reset();
    step(1, 1, 0, 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      if (out_valid) begin
        seen++;
        chk("t5_pc", 48'(out_pc), 48'd0);
      end
    end
    chk("t5_count", 48'(seen), 48'd1);
    for (int i = 0; i < 10 && !out_valid; i++) step(1, 1, 0, 0);
    chk("t5_resume_pc", 48'(out_pc), 48'd3);
    // 6: async reset with two buffered entries, then restart at 0
    repeat (5) step(1, 0, 0, 0);
    chk("t6_full", 48'(out_valid), 48'd1);
    do_reset();
    for (int i = 0; i < 10 && !out_valid; i++) step(1, 1, 0, 0);
    chk("t6_restart_pc", 48'(out_pc), 48'd0);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 19) == 0), 24'($urandom_range(0, 70)));
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
